// File: rtl/jtopl_wrseq.sv
// jtopl_wrseq: queued OPL register-write sequencer.
// Drives the jtopl CPU port with OPL recovery timing.
module jtopl_wrseq #(
  parameter int DW2    = 3,
  parameter int STROBE = 2,
  parameter int AWAIT  = 12,
  parameter int DWAIT  = 84
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [7:0]     req_reg,
  input  logic [7:0]     req_val,
  input  logic           flush,
  output logic [7:0]     opl_din,
  output logic           opl_addr,
  output logic           opl_cs_n,
  output logic           opl_wr_n,
  output logic [DW2:0]   level,
  output logic           busy
);

  localparam int DEPTH = 1 << DW2;
  localparam int LW    = DW2 + 1;
  localparam int M1    = (STROBE > AWAIT) ? STROBE : AWAIT;
  localparam int MAXT  = (M1 > DWAIT) ? M1 : DWAIT;
  localparam int CW    = $clog2(MAXT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AWR,
    S_AWT,
    S_DWR,
    S_DWT
  } state_t;

  logic [15:0]    r_mem [DEPTH];
  logic [DW2-1:0] r_wp;
  logic [DW2-1:0] r_rp;
  logic [LW-1:0]  r_level;

  state_t         r_state;
  state_t         w_nstate;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_ncnt;
  logic [7:0]     r_din;
  logic [7:0]     w_ndin;
  logic           r_addr;
  logic           w_naddr;
  logic           r_stb_n;
  logic           w_nstb_n;

  logic           w_push;
  logic           w_pop;
  logic           w_has;
  logic           w_last;
  logic [15:0]    w_head;

  assign w_push    = req_valid & req_ready;
  assign w_has     = r_level != '0;
  assign w_last    = r_cnt == CW'(1);
  assign w_head    = r_mem[r_rp];

  assign req_ready = r_level != LW'(DEPTH);
  assign level     = r_level;
  assign busy      = (r_state != S_IDLE) | w_has;
  assign opl_din   = r_din;
  assign opl_addr  = r_addr;
  assign opl_cs_n  = r_stb_n;
  assign opl_wr_n  = r_stb_n;

  // FIFO storage, pointers and occupancy; flush wins over push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= {req_reg, req_val};
        r_wp        <= r_wp + DW2'(1);
      end
      if (w_pop) r_rp <= r_rp + DW2'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  // Bus sequencer next state, counter and registered bus values
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_ndin   = r_din;
    w_naddr  = r_addr;
    w_nstb_n = r_stb_n;
    w_pop    = 1'b0;
    if (cen) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_has) begin
            w_pop    = 1'b1;
            w_nstate = S_AWR;
            w_ncnt   = CW'(STROBE);
            w_ndin   = w_head[15:8];
            w_naddr  = 1'b0;
            w_nstb_n = 1'b0;
          end
        end
        S_AWR: begin
          if (w_last) begin
            w_nstate = S_AWT;
            w_ncnt   = CW'(AWAIT);
            w_nstb_n = 1'b1;
          end else begin
            w_ncnt = r_cnt - CW'(1);
          end
        end
        S_AWT: begin
          if (w_last) begin
            w_nstate = S_DWR;
            w_ncnt   = CW'(STROBE);
            w_ndin   = w_head[7:0];
            w_naddr  = 1'b1;
            w_nstb_n = 1'b0;
          end else begin
            w_ncnt = r_cnt - CW'(1);
          end
        end
        S_DWR: begin
          if (w_last) begin
            w_nstate = S_DWT;
            w_ncnt   = CW'(DWAIT);
            w_nstb_n = 1'b1;
          end else begin
            w_ncnt = r_cnt - CW'(1);
          end
        end
        S_DWT: begin
          if (w_last && w_has) begin
            w_pop    = 1'b1;
            w_nstate = S_AWR;
            w_ncnt   = CW'(STROBE);
            w_ndin   = w_head[15:8];
            w_naddr  = 1'b0;
            w_nstb_n = 1'b0;
          end else if (w_last) begin
            w_nstate = S_IDLE;
            w_ncnt   = '0;
          end else begin
            w_ncnt = r_cnt - CW'(1);
          end
        end
        default: begin
          w_nstate = S_IDLE;
          w_ncnt   = '0;
          w_nstb_n = 1'b1;
        end
      endcase
    end
  end

  // The value register holds the popped entry's data byte
  // until the data strobe, since the FIFO head may move on.
  logic [7:0] r_val;

  // Sequencer state register; strobes released by async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_din   <= '0;
      r_addr  <= 1'b0;
      r_stb_n <= 1'b1;
      r_val   <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_addr  <= w_naddr;
      r_stb_n <= w_nstb_n;
      if (w_pop) r_val <= w_head[7:0];
      if (cen && r_state == S_AWT && w_last) r_din <= r_val;
      else r_din <= w_ndin;
    end
  end

endmodule

// File: tb/tb_jtopl_wrseq.sv
// tb_jtopl_wrseq: vector tables, directed corner cases
// and random traffic against a write-timeline model.
module tb_jtopl_wrseq;

  localparam int DW2    = 3;
  localparam int STROBE = 2;
  localparam int AWAIT  = 12;
  localparam int DWAIT  = 84;
  localparam int DEPTH  = 8;
  localparam int TOTAL  = 2 * STROBE + AWAIT + DWAIT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       req_valid = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] req_reg = '0;
  logic [7:0] req_val = '0;
  logic       req_ready;
  logic [7:0] opl_din;
  logic       opl_addr;
  logic       opl_cs_n;
  logic       opl_wr_n;
  logic [3:0] level;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  jtopl_wrseq #(
    .DW2(DW2), .STROBE(STROBE), .AWAIT(AWAIT), .DWAIT(DWAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_val(req_val), .flush(flush),
    .opl_din(opl_din), .opl_addr(opl_addr),
    .opl_cs_n(opl_cs_n), .opl_wr_n(opl_wr_n),
    .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  // model: queue of pending writes plus the tick offset
  // into the write currently on the bus
  logic [15:0] mq[$];
  bit          m_act;
  int          m_t;
  logic [15:0] m_cur;
  logic [7:0]  m_din;
  logic        m_addr;

  function automatic void m_reset();
    mq.delete();
    m_act  = 0;
    m_t    = 0;
    m_cur  = '0;
    m_din  = '0;
    m_addr = 1'b0;
  endfunction

  function automatic void m_edge(input logic c, v,
                                 input logic [7:0] r, d,
                                 input logic f);
    int sz;
    bit push;
    sz   = mq.size();
    push = v && (sz < DEPTH);
    if (c) begin
      if (m_act) begin
        m_t++;
        if (m_t == TOTAL) m_act = 0;
      end
      if (!m_act && sz != 0) begin
        m_cur = mq.pop_front();
        m_act = 1;
        m_t   = 0;
      end
      if (m_act && m_t == 0) begin
        m_din  = m_cur[15:8];
        m_addr = 1'b0;
      end else if (m_act && m_t == STROBE + AWAIT) begin
        m_din  = m_cur[7:0];
        m_addr = 1'b1;
      end
    end
    if (f) mq.delete();
    else if (push) mq.push_back({r, d});
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic m_check();
    logic        low;
    logic [16:0] exp;
    logic [16:0] act;
    low = m_act && (m_t < STROBE ||
          (m_t >= STROBE + AWAIT && m_t < 2 * STROBE + AWAIT));
    exp = {~low, ~low, m_addr, m_din, 4'(mq.size()),
           (m_act || mq.size() != 0), (mq.size() != DEPTH)};
    act = {opl_cs_n, opl_wr_n, opl_addr, opl_din, level,
           busy, req_ready};
    chk("bus cs/wr/a/din/lvl/busy/rdy", 32'(act), 32'(exp));
  endtask

  task automatic step(input logic c, v, input logic [7:0] r, d,
                      input logic f);
    cen = c; req_valid = v; req_reg = r; req_val = d; flush = f;
    @(posedge clk);
    m_edge(c, v, r, d, f);
    #1;
    m_check();
  endtask

  task automatic do_reset();
    req_valid = 1'b0; flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst_cs_n", 32'(opl_cs_n), 1);
    chk("rst_wr_n", 32'(opl_wr_n), 1);
    chk("rst_level", 32'(level), 0);
    m_check();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] r;
    logic [7:0] d;
    int         lvl;
    logic       rdy;
  } vec_t;

  vec_t tbl[9];

  int  alow, dlow, dfirst, bfall, starts;
  bit  prev_n, found;

  initial begin
    #100_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 9; i++) begin
      tbl[i].v   = 1'b1;
      tbl[i].r   = 8'(16 + 3 * i);
      tbl[i].d   = 8'(200 - 7 * i);
      tbl[i].lvl = (i < 8) ? i + 1 : 8;
      tbl[i].rdy = (i < 7);
    end

    // reset state
    m_reset();
    #12;
    chk("reset_cs_n", 32'(opl_cs_n), 1);
    chk("reset_wr_n", 32'(opl_wr_n), 1);
    chk("reset_addr", 32'(opl_addr), 0);
    chk("reset_din", 32'(opl_din), 0);
    chk("reset_level", 32'(level), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_ready", 32'(req_ready), 1);
    rst_n = 1'b1;

    // single write, cen=1
    step(1, 1, 8'h20, 8'h01, 0);
    alow = 0; dlow = 0; dfirst = -1; bfall = -1;
    for (int i = 0; i <= 110; i++) begin
      step(1, 0, 0, 0, 0);
      if (!opl_wr_n && !opl_addr && opl_din == 8'h20) alow++;
      if (!opl_wr_n && opl_addr && opl_din == 8'h01) begin
        dlow++;
        if (dfirst < 0) dfirst = i;
      end
      if (!busy && bfall < 0) bfall = i;
    end
    chk("s1_addr_low_clk", 32'(alow), 2);
    chk("s1_data_low_clk", 32'(dlow), 2);
    chk("s1_data_start", 32'(dfirst), 14);
    chk("s1_busy_fall", 32'(bfall), 100);

    // fill with cen=0, table driven
    for (int i = 0; i < 9; i++) begin
      step(0, tbl[i].v, tbl[i].r, tbl[i].d, 0);
      chk("s2_level", 32'(level), 32'(tbl[i].lvl));
      chk("s2_ready", 32'(req_ready), 32'(tbl[i].rdy));
    end
    starts = 0; bfall = -1; prev_n = 1'b1;
    for (int i = 0; i < 1000 && bfall < 0; i++) begin
      step(1, 0, 0, 0, 0);
      if (!opl_wr_n && !opl_addr && prev_n) starts++;
      prev_n = opl_wr_n;
      if (!busy) bfall = i;
    end
    chk("s2_writes", 32'(starts), 8);
    chk("s2_busy_fall", 32'(bfall), 800);

    // cen 1-of-4
    step(0, 1, 8'h33, 8'hC4, 0);
    alow = 0; dlow = 0; dfirst = -1; bfall = -1;
    for (int k = 0; k <= 450; k++) begin
      step(k % 4 == 0, 0, 0, 0, 0);
      if (!opl_wr_n && !opl_addr && opl_din == 8'h33) alow++;
      if (!opl_wr_n && opl_addr && opl_din == 8'hC4) begin
        dlow++;
        if (dfirst < 0) dfirst = k;
      end
      if (!busy && bfall < 0) bfall = k;
    end
    chk("s3_addr_low_clk", 32'(alow), 8);
    chk("s3_data_low_clk", 32'(dlow), 8);
    chk("s3_data_start", 32'(dfirst), 56);
    chk("s3_busy_fall", 32'(bfall), 400);

    // flush during the first address wait
    for (int i = 0; i < 3; i++) step(0, 1, 8'(8'hA0 + i), 8'(i), 0);
    starts = 0; prev_n = 1'b1;
    for (int i = 0; i < 120; i++) begin
      step(1, 0, 0, 0, i == 4);
      if (i == 4) chk("s4_level_flushed", 32'(level), 0);
      if (!opl_wr_n && !opl_addr && prev_n) starts++;
      prev_n = opl_wr_n;
    end
    chk("s4_writes", 32'(starts), 1);
    chk("s4_busy", 32'(busy), 0);

    // reset during the data strobe
    step(1, 1, 8'h11, 8'h22, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1, 0, 0, 0, 0);
      if (opl_addr && !opl_wr_n) found = 1;
    end
    chk("s5_dwr_reached", 32'(found), 1);
    do_reset();
    step(1, 1, 8'h40, 8'h55, 0);
    starts = 0; dlow = 0; prev_n = 1'b1;
    for (int i = 0; i < 105; i++) begin
      step(1, 0, 0, 0, 0);
      if (!opl_wr_n && !opl_addr && prev_n) starts++;
      if (!opl_wr_n && opl_addr && opl_din == 8'h55) dlow++;
      prev_n = opl_wr_n;
    end
    chk("s5_writes", 32'(starts), 1);
    chk("s5_data_low_clk", 32'(dlow), 2);
    chk("s5_busy", 32'(busy), 0);

    // push on the pop edge
    for (int i = 0; i < 3; i++) step(0, 1, 8'(i), 8'(i), 0);
    chk("s6_level_pre", 32'(level), 3);
    step(1, 1, 8'h77, 8'h88, 0);
    chk("s6_level_same", 32'(level), 3);
    chk("s6_popped", 32'(opl_wr_n), 0);
    for (int i = 0; i < 500 && busy; i++) step(1, 0, 0, 0, 0);
    chk("s6_drained", 32'(busy), 0);

    // random traffic
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(1999) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(3) != 0, $urandom_range(9) < 2,
             8'($urandom), 8'($urandom),
             $urandom_range(299) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
